// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined two's-complement adder/subtractor with a valid/ready stream.
// The operands are split into SLICE-bit lookahead slices, and one slice is resolved per stage.
// The slice carry is registered between stages. Operand bits not yet processed and sum
// bits already resolved travel through skew registers alongside each beat.
// Optional feature: define ADDSUB_PIPE_SAT_EN for signed saturation of the result.
module addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             add_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);
    localparam int NSTG = WIDTH / SLICE;
    localparam int MSB  = WIDTH - 1;
    localparam int LW   = WIDTH - SLICE;

    // The skew registers are sized per stage, so the design needs at least two slices.
    if ((WIDTH % SLICE) != 0 || WIDTH < 8 || NSTG < 2) begin : g_param_chk
        $error("addsub_pipe: WIDTH must be a multiple of SLICE, at least 8, with two or more slices");
    end

    // Resolves one slice using generate/propagate lookahead. Returns {carry_out, sum}.
    function automatic logic [SLICE:0] cla_slice(input logic [SLICE-1:0] i_x,
                                                 input logic [SLICE-1:0] i_y,
                                                 input logic             i_c);
        logic [SLICE-1:0] l_g;
        logic [SLICE-1:0] l_p;
        logic [SLICE:0]   l_c;
        l_g    = i_x & i_y;
        l_p    = i_x ^ i_y;
        l_c    = '0;
        l_c[0] = i_c;
        for (int i = 0; i < SLICE; i++) begin
            l_c[i+1] = l_g[i] | (l_p[i] & l_c[i]);
        end
        return {l_c[SLICE], l_p ^ l_c[SLICE-1:0]};
    endfunction

    logic w_adv;
    logic r_out_v;

    // One global shift enable. A full pipe stalls as a whole, including its bubbles.
    assign w_adv    = ~r_out_v | out_ready;
    assign in_ready = w_adv;

    for (genvar k = 0; k < NSTG - 1; k++) begin : g_stg
        localparam int IW = WIDTH - k * SLICE;
        localparam int OW = IW - SLICE;
        localparam int SW = (k + 1) * SLICE;

        logic [IW-1:0]  w_pa;
        logic [IW-1:0]  w_pm;
        logic           w_pc;
        logic           w_pv;
        logic [SLICE:0] w_res;
        logic [SW-1:0]  w_snew;

        logic           r_v;
        logic           r_c;
        logic [OW-1:0]  r_a;
        logic [OW-1:0]  r_m;
        logic [SW-1:0]  r_s;

        if (k == 0) begin : g_src
            assign w_pa   = a;
            assign w_pm   = b ^ {WIDTH{~add_ctrl}};
            assign w_pc   = ~add_ctrl;
            assign w_pv   = in_valid;
            assign w_snew = w_res[SLICE-1:0];
        end else begin : g_src
            assign w_pa   = g_stg[k-1].r_a;
            assign w_pm   = g_stg[k-1].r_m;
            assign w_pc   = g_stg[k-1].r_c;
            assign w_pv   = g_stg[k-1].r_v;
            assign w_snew = {w_res[SLICE-1:0], g_stg[k-1].r_s};
        end

        assign w_res = cla_slice(w_pa[SLICE-1:0], w_pm[SLICE-1:0], w_pc);

        // Stage register. It shifts on the global enable and holds otherwise.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
                r_a <= '0;
                r_m <= '0;
                r_s <= '0;
            end else if (w_adv) begin
                r_v <= w_pv;
                r_c <= w_res[SLICE];
                r_a <= w_pa[IW-1:SLICE];
                r_m <= w_pm[IW-1:SLICE];
                r_s <= w_snew;
            end
        end
    end

    logic [SLICE-1:0] w_fa;
    logic [SLICE-1:0] w_fm;
    logic             w_fc;
    logic             w_fv;
    logic [LW-1:0]    w_flo;
    logic [SLICE:0]   w_fres;
    logic [WIDTH-1:0] w_raw;
    logic [WIDTH-1:0] w_fsum;
    logic             w_fovf;

    assign w_fa   = g_stg[NSTG-2].r_a;
    assign w_fm   = g_stg[NSTG-2].r_m;
    assign w_fc   = g_stg[NSTG-2].r_c;
    assign w_fv   = g_stg[NSTG-2].r_v;
    assign w_flo  = g_stg[NSTG-2].r_s;
    assign w_fres = cla_slice(w_fa, w_fm, w_fc);
    assign w_raw  = {w_fres[SLICE-1:0], w_flo};

    // The top slice holds the MSBs of A and of the post-XOR B that are needed for signed overflow.
    assign w_fovf = (w_fa[SLICE-1] == w_fm[SLICE-1]) && (w_raw[MSB] != w_fa[SLICE-1]);

`ifdef ADDSUB_PIPE_SAT_EN
    // Clamp toward the sign of A on overflow. The carry is still the unsaturated one.
    always_comb begin
        w_fsum = w_raw;
        if (w_fovf) begin
            w_fsum = w_fa[SLICE-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign w_fsum = w_raw;
`endif

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic             r_neg;

    // Final stage: resolve the top slice and register the sum together with its flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_v <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
        end else if (w_adv) begin
            r_out_v <= w_fv;
            r_sum   <= w_fsum;
            r_cout  <= w_fres[SLICE];
            r_ovf   <= w_fovf;
            r_zero  <= (w_fsum == '0);
            r_neg   <= w_fsum[MSB];
        end
    end

    assign out_valid = r_out_v;
    assign sum       = r_sum;
    assign c_out     = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;
    assign neg       = r_neg;

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe with the default parameters (WIDTH=16, SLICE=4).
// The expected results come from signed and unsigned integer arithmetic on the operands.
module tb_addsub_pipe;
    localparam int W = 16;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         add_ctrl  = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;
    logic         zero;
    logic         neg;

    int n_vec = 0;
    int n_err = 0;
    int n_out = 0;

    logic [W+3:0] exp_q[$];
    logic [W+4:0] prev_out  = '0;
    logic         prev_hold = 1'b0;

    always #5 clk = ~clk;

    addsub_pipe #(.WIDTH(W), .SLICE(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .add_ctrl(add_ctrl), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out), .ovf(ovf), .zero(zero), .neg(neg)
    );

    // The reference result is packed as {c_out, ovf, zero, neg, sum}.
    function automatic logic [W+3:0] model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                           input logic iadd);
        int sa, sb, ua, ub, r;
        logic c, o;
        logic [W-1:0] s;
        sa = int'($signed(ia));
        sb = int'($signed(ib));
        ua = int'(ia);
        ub = int'(ib);
        r  = iadd ? sa + sb : sa - sb;
        o  = (r > 32767) || (r < -32768);
        c  = iadd ? (ua + ub > 65535) : (ua >= ub);
        s  = r[W-1:0];
`ifdef ADDSUB_PIPE_SAT_EN
        if (o) s = (r > 0) ? 16'h7FFF : 16'h8000;
`endif
        return {c, o, (s == '0), s[W-1], s};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    // Compare process: check the handshake rule, hold stability, and in-order results every cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            check("in_ready_rule", {31'b0, in_ready}, {31'b0, (!out_valid || out_ready)});
            if (prev_hold)
                check("stall_hold", {11'b0, out_valid, c_out, ovf, zero, neg, sum}, {11'b0, prev_out});
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) fail_now("unexpected_beat");
                else check("result", {12'b0, c_out, ovf, zero, neg, sum}, {12'b0, exp_q.pop_front()});
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, add_ctrl));
            prev_hold = out_valid && !out_ready;
            prev_out  = {out_valid, c_out, ovf, zero, neg, sum};
        end
    end

    task automatic drive(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic iadd);
        a        = ia;
        b        = ib;
        add_ctrl = iadd;
        in_valid = 1'b1;
    endtask

    task automatic drive_rand();
        drive(W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
    endtask

    // Call this with the pipe empty, just after a rising edge, and with out_ready=1.
    task automatic run_one(input string nm, input logic [W-1:0] ia, input logic [W-1:0] ib,
                           input logic iadd, input logic [W+3:0] expv);
        int lat;
        lat = 0;
        drive(ia, ib, iadd);
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        check({nm, "_latency"}, lat, 4);
        check(nm, {12'b0, c_out, ovf, zero, neg, sum}, {12'b0, expv});
        @(posedge clk);
        #1;
    endtask

    function automatic logic ready_pat(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 2) return 1'b0;
        if ((cyc % 11) >= 3 && (cyc % 11) <= 5) return 1'b0;
        return ($urandom_range(0, 3) != 0);
    endfunction

    // Offer n random beats back-to-back. mode 0: out_ready=1, 1: pseudo-random out_ready, 2: out_ready=0.
    task automatic stream(input int n, input int mode);
        int sent, cyc;
        logic acc;
        sent = 0;
        cyc  = 0;
        drive_rand();
        while (sent < n && cyc < 400) begin
            out_ready = ready_pat(mode, cyc);
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                sent++;
                if (sent < n) drive_rand();
                else in_valid = 1'b0;
            end
        end
        if (sent < n) begin
            in_valid = 1'b0;
            fail_now("stream_accept_timeout");
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            @(posedge clk);
            #1;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int base, cnt;
        #200000;
        $display("FAIL watchdog_timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, cnt;
        @(posedge clk);
        #1 check("reset_outputs", {11'b0, out_valid, c_out, ovf, zero, neg, sum}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        run_one("add_00ff_0001", 16'h00FF, 16'h0001, 1'b1, {4'b0000, 16'h0100});
        run_one("sub_0005_0007", 16'h0005, 16'h0007, 1'b0, {4'b0001, 16'hFFFE});
        run_one("sub_0007_0005", 16'h0007, 16'h0005, 1'b0, {4'b1000, 16'h0002});
        run_one("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b1, {4'b1010, 16'h0000});
`ifdef ADDSUB_PIPE_SAT_EN
        run_one("add_7fff_0001", 16'h7FFF, 16'h0001, 1'b1, {4'b0100, 16'h7FFF});
        run_one("sub_8000_0001", 16'h8000, 16'h0001, 1'b0, {4'b1101, 16'h8000});
`else
        run_one("add_7fff_0001", 16'h7FFF, 16'h0001, 1'b1, {4'b0101, 16'h8000});
        run_one("sub_8000_0001", 16'h8000, 16'h0001, 1'b0, {4'b1100, 16'h7FFF});
`endif

        base = n_out;
        stream(16, 1);
        drain();
        check("stream_count", n_out - base, 16);

        stream(4, 2);
        check("fill_out_valid", {31'b0, out_valid}, 32'd1);
        drive_rand();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("full_in_ready", {31'b0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
            else break;
        end
        check("release_burst", cnt, 4);
        @(posedge clk);
        #1;
        drain();

        stream(3, 0);
        @(posedge clk);
        #1;
        check("inflight_before_reset", {31'b0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1 check("async_reset_outputs", {11'b0, out_valid, c_out, ovf, zero, neg, sum}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_one("post_reset_beat", 16'h1234, 16'h4321, 1'b1, {4'b0000, 16'h5555});
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
